// File: rtl/matrix_dac_seq_if.sv
// Control/address bundle between a host and the matrix_dac_seq sequencer.
interface matrix_dac_seq_if;
  logic        trg;
  logic [4:0]  row1;
  logic [12:0] column;
  logic [9:0]  in_addr;
  logic [16:0] coe_addr;
  logic        mac_clr;
  logic        mac_en;
  logic        dac_out_en;
  logic [4:0]  out_row;
  logic [11:0] out_col;
  logic [3:0]  STATE;
  logic        busy;
  logic        done;

  modport master (
    output trg, row1, column,
    input  in_addr, coe_addr, mac_clr, mac_en, dac_out_en,
    input  out_row, out_col, STATE, busy, done
  );

  modport slave (
    input  trg, row1, column,
    output in_addr, coe_addr, mac_clr, mac_en, dac_out_en,
    output out_row, out_col, STATE, busy, done
  );
endinterface

// File: rtl/matrix_dac_seq.sv
// Matrix-multiply address sequencer with MAC/DAC strobes aligned to RAM read latency.
// Optional abort input enabled by defining MATRIX_DAC_SEQ_ABORT_EN.
module matrix_dac_seq #(
  parameter int unsigned RD_LAT  = 2,
  parameter int unsigned K_DEPTH = 32
) (
  input  logic clk_250MHz,
  input  logic rst,
`ifdef MATRIX_DAC_SEQ_ABORT_EN
  input  logic abort,
`endif
  matrix_dac_seq_if.slave bus
);

  localparam logic [3:0] IDLE  = 4'd0;
  localparam logic [3:0] LOAD  = 4'd1;
  localparam logic [3:0] RUN   = 4'd2;
  localparam logic [3:0] DRAIN = 4'd3;
  localparam logic [3:0] DONE  = 4'd4;

  localparam logic [4:0] K_LAST = 5'(K_DEPTH - 1);

  logic [3:0]  state_q, state_d;
  logic [4:0]  row1_q, row1_d;
  logic [11:0] col_q, col_d;
  logic [4:0]  r_q, r_d;
  logic [11:0] c_q, c_d;
  logic [4:0]  k_q, k_d;
  logic [2:0]  drain_q, drain_d;
  logic [RD_LAT-1:0] clr_pipe_q, clr_pipe_d;
  logic [RD_LAT-1:0] en_pipe_q, en_pipe_d;
  logic [RD_LAT-1:0] last_pipe_q, last_pipe_d;
  logic [16:0] rc_pipe_q [RD_LAT];
  logic [16:0] rc_pipe_d [RD_LAT];
  logic        dac_q, dac_d;
  logic [4:0]  out_row_q, out_row_d;
  logic [11:0] out_col_q, out_col_d;

  logic issue;
  logic final_issue;
  logic abort_hit;

`ifdef MATRIX_DAC_SEQ_ABORT_EN
  assign abort_hit = abort && (state_q == LOAD || state_q == RUN || state_q == DRAIN);
`else
  assign abort_hit = 1'b0;
`endif

  assign issue       = (state_q == RUN);
  assign final_issue = issue && (r_q == row1_q) && (c_q == col_q) && (k_q == K_LAST);

  always_comb begin
    state_d   = state_q;
    row1_d    = row1_q;
    col_d     = col_q;
    r_d       = r_q;
    c_d       = c_q;
    k_d       = k_q;
    drain_d   = drain_q;
    out_row_d = out_row_q;
    out_col_d = out_col_q;

    // Counters clear on the LOAD->RUN edge so the address outputs keep
    // their previous value for the whole LOAD cycle.
    case (state_q)
      IDLE: begin
        if (bus.trg) begin
          row1_d  = bus.row1;
          col_d   = bus.column[12] ? 12'hFFF : bus.column[11:0];
          state_d = LOAD;
        end
      end
      LOAD: begin
        r_d     = '0;
        c_d     = '0;
        k_d     = '0;
        state_d = RUN;
      end
      RUN: begin
        if (final_issue) begin
          drain_d = '0;
          state_d = DRAIN;
        end else if (k_q == K_LAST) begin
          k_d = '0;
          if (c_q == col_q) begin
            c_d = '0;
            r_d = r_q + 5'd1;
          end else begin
            c_d = c_q + 12'd1;
          end
        end else begin
          k_d = k_q + 5'd1;
        end
      end
      DRAIN: begin
        if (drain_q == 3'(RD_LAT)) state_d = DONE;
        else                       drain_d = drain_q + 3'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    clr_pipe_d[0]  = issue && (k_q == '0);
    en_pipe_d[0]   = issue && (k_q != '0);
    last_pipe_d[0] = issue && (k_q == K_LAST);
    rc_pipe_d[0]   = {r_q, c_q};
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      clr_pipe_d[i]  = clr_pipe_q[i-1];
      en_pipe_d[i]   = en_pipe_q[i-1];
      last_pipe_d[i] = last_pipe_q[i-1];
      rc_pipe_d[i]   = rc_pipe_q[i-1];
    end

    dac_d = last_pipe_q[RD_LAT-1];
    if (dac_d) begin
      out_row_d = rc_pipe_q[RD_LAT-1][16:12];
      out_col_d = rc_pipe_q[RD_LAT-1][11:0];
    end

    if (abort_hit) begin
      state_d     = IDLE;
      clr_pipe_d  = '0;
      en_pipe_d   = '0;
      last_pipe_d = '0;
      dac_d       = 1'b0;
    end
  end

  always_ff @(posedge clk_250MHz or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      row1_q      <= '0;
      col_q       <= '0;
      r_q         <= '0;
      c_q         <= '0;
      k_q         <= '0;
      drain_q     <= '0;
      clr_pipe_q  <= '0;
      en_pipe_q   <= '0;
      last_pipe_q <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) rc_pipe_q[i] <= '0;
      dac_q       <= 1'b0;
      out_row_q   <= '0;
      out_col_q   <= '0;
    end else begin
      state_q     <= state_d;
      row1_q      <= row1_d;
      col_q       <= col_d;
      r_q         <= r_d;
      c_q         <= c_d;
      k_q         <= k_d;
      drain_q     <= drain_d;
      clr_pipe_q  <= clr_pipe_d;
      en_pipe_q   <= en_pipe_d;
      last_pipe_q <= last_pipe_d;
      for (int unsigned i = 0; i < RD_LAT; i++) rc_pipe_q[i] <= rc_pipe_d[i];
      dac_q       <= dac_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
    end
  end

  assign bus.in_addr    = {r_q, k_q};
  assign bus.coe_addr   = {k_q, c_q};
  assign bus.mac_clr    = clr_pipe_q[RD_LAT-1];
  assign bus.mac_en     = en_pipe_q[RD_LAT-1];
  assign bus.dac_out_en = dac_q;
  assign bus.out_row    = out_row_q;
  assign bus.out_col    = out_col_q;
  assign bus.STATE      = state_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DONE);

endmodule

// File: tb/tb_matrix_dac_seq.sv
// Randomized bench for matrix_dac_seq against a timing-offset reference model.
`timescale 1ns/1ps
module tb_matrix_dac_seq;
  localparam int LAT   = 2;
  localparam int K     = 32;
  localparam int LAT_B = 1;
  localparam int K_B   = 2;

  logic clk = 1'b0;
  logic rst;
  always #2 clk = ~clk;

  matrix_dac_seq_if bus_a ();
  matrix_dac_seq_if bus_b ();
`ifdef MATRIX_DAC_SEQ_ABORT_EN
  logic abort_a = 1'b0;
  logic abort_b = 1'b0;
`endif

  matrix_dac_seq #(.RD_LAT(LAT), .K_DEPTH(K)) dut_a (
    .clk_250MHz(clk),
    .rst(rst),
`ifdef MATRIX_DAC_SEQ_ABORT_EN
    .abort(abort_a),
`endif
    .bus(bus_a)
  );

  matrix_dac_seq #(.RD_LAT(LAT_B), .K_DEPTH(K_B)) dut_b (
    .clk_250MHz(clk),
    .rst(rst),
`ifdef MATRIX_DAC_SEQ_ABORT_EN
    .abort(abort_b),
`endif
    .bus(bus_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state: a run is fully described by its start edge and shape.
  bit          mon_en  = 1'b0;
  bit          active  = 1'b0;
  bit          aborted = 1'b0;
  int          t0, abort_d, mr, mc, n_iss;
  logic [9:0]  hold_in  = '0;
  logic [16:0] hold_coe = '0;
  int          dac_cnt, clr_cnt;

  always @(negedge clk) begin
    int d, j, g;
    logic [3:0] es;
    bit eclr, een, edac;
    int er, ec;
    es = 4'd0; eclr = 0; een = 0; edac = 0; er = 0; ec = 0;
    if (mon_en) begin
      d = cyc - t0;
      if (active && !(aborted && d > abort_d)) begin
        if (d == 0)                                es = 4'd1;
        else if (d >= 1 && d <= n_iss)             es = 4'd2;
        else if (d > n_iss && d <= n_iss + LAT + 1) es = 4'd3;
        else if (d == n_iss + LAT + 2)             es = 4'd4;
        j = d - 1 - LAT;
        if (j >= 0 && j < n_iss) begin
          eclr = (j % K == 0);
          een  = !eclr;
        end
        j = d - 2 - LAT;
        if (j >= 0 && j < n_iss && j % K == K - 1) begin
          edac = 1;
          g = j / K;
          er = g / (mc + 1);
          ec = g % (mc + 1);
        end
        if (es == 4'd2) begin
          j = d - 1;
          g = j / K;
          hold_in  = {5'(g / (mc + 1)), 5'(j % K)};
          hold_coe = {5'(j % K), 12'(g % (mc + 1))};
        end
      end
      check("state", 32'(bus_a.STATE), 32'(es));
      check("busy", 32'(bus_a.busy), 32'(es != 4'd0));
      check("done", 32'(bus_a.done), 32'(es == 4'd4));
      check("mac_clr", 32'(bus_a.mac_clr), 32'(eclr));
      check("mac_en", 32'(bus_a.mac_en), 32'(een));
      check("dac_out_en", 32'(bus_a.dac_out_en), 32'(edac));
      check("in_addr", 32'(bus_a.in_addr), 32'(hold_in));
      check("coe_addr", 32'(bus_a.coe_addr), 32'(hold_coe));
      if (edac) begin
        check("out_row", 32'(bus_a.out_row), er);
        check("out_col", 32'(bus_a.out_col), ec);
      end
      if (bus_a.dac_out_en) dac_cnt++;
      if (bus_a.mac_clr) clr_cnt++;
    end
  end

  task automatic start_a(input logic [4:0] r1, input logic [12:0] col);
    @(negedge clk);
    bus_a.row1   = r1;
    bus_a.column = col;
    bus_a.trg    = 1'b1;
    @(posedge clk);
    #1;
    t0      = cyc;
    mr      = int'(r1);
    mc      = (int'(col) > 4095) ? 4095 : int'(col);
    n_iss   = (mr + 1) * (mc + 1) * K;
    aborted = 1'b0;
    active  = 1'b1;
    dac_cnt = 0;
    clr_cnt = 0;
    bus_a.trg    = 1'b0;
    bus_a.row1   = 5'($urandom);
    bus_a.column = 13'($urandom);
  endtask

  task automatic finish_a(input bit poke_run, input bit poke_done, input bit do_abort);
    int d, fin;
    fin = n_iss + LAT + 2;
    d   = 0;
    while (aborted ? (d < abort_d + 3) : (d < fin + 2)) begin
      @(negedge clk);
      d = cyc - t0;
      bus_a.trg = 1'b0;
`ifdef MATRIX_DAC_SEQ_ABORT_EN
      abort_a = 1'b0;
      if (do_abort && d == n_iss + 1) begin
        abort_a = 1'b1;
        aborted = 1'b1;
        abort_d = d;
      end
`endif
      if (poke_run && d == 5) bus_a.trg = 1'b1;
      if (poke_done && d == fin) bus_a.trg = 1'b1;
    end
    bus_a.trg = 1'b0;
    check("pulse_count", dac_cnt, aborted ? (mr + 1) * (mc + 1) - 1 : (mr + 1) * (mc + 1));
    if (!aborted) check("clr_count", clr_cnt, (mr + 1) * (mc + 1));
  endtask

  task automatic run_a(input logic [4:0] r1, input logic [12:0] col,
                       input bit poke_run, input bit poke_done, input bit do_abort);
    start_a(r1, col);
    finish_a(poke_run, poke_done, do_abort);
  endtask

  int cnt_b = 0, maxc_b = 0, lastcol_b = -1;
  always @(negedge clk) begin
    if (bus_b.dac_out_en) begin
      cnt_b++;
      lastcol_b = int'(bus_b.out_col);
    end
    if (bus_b.STATE == 4'd2 && int'(bus_b.coe_addr[11:0]) > maxc_b) maxc_b = int'(bus_b.coe_addr[11:0]);
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tb0, done_d;
    bit seen;
    rst = 1'b1;
    bus_a.trg = 1'b0; bus_a.row1 = '0; bus_a.column = '0;
    bus_b.trg = 1'b0; bus_b.row1 = '0; bus_b.column = '0;
    repeat (2) @(negedge clk);
    check("rst_state", 32'(bus_a.STATE), 0);
    check("rst_in_addr", 32'(bus_a.in_addr), 0);
    check("rst_out_col", 32'(bus_a.out_col), 0);
    rst = 1'b0;
    t0 = cyc;
    mon_en = 1'b1;

    run_a(5'd0, 13'd0, 0, 0, 0);
    run_a(5'd1, 13'd2, 0, 0, 0);
    run_a(5'd1, 13'd2, 1, 1, 0);
    for (int n = 0; n < 12; n++)
      run_a(5'($urandom_range(0, 3)), 13'($urandom_range(0, 5)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
`ifdef MATRIX_DAC_SEQ_ABORT_EN
    run_a(5'd1, 13'd1, 0, 0, 1);
`endif

    // Asynchronous reset in RUN cycle 10.
    start_a(5'd1, 13'd2);
    while (cyc - t0 < 11) @(negedge clk);
    #1 rst = 1'b1;
    active   = 1'b0;
    hold_in  = '0;
    hold_coe = '0;
    #0.5;
    check("arst_state", 32'(bus_a.STATE), 0);
    check("arst_busy", 32'(bus_a.busy), 0);
    check("arst_in_addr", 32'(bus_a.in_addr), 0);
    check("arst_coe_addr", 32'(bus_a.coe_addr), 0);
    check("arst_strobes", 32'({bus_a.mac_clr, bus_a.mac_en, bus_a.dac_out_en, bus_a.done}), 0);
    @(negedge clk);
    rst = 1'b0;
    dac_cnt = 0;
    repeat (60) @(negedge clk);
    check("arst_no_pulse", dac_cnt, 0);

    // Column clamp on a short-K instance.
    @(negedge clk);
    bus_b.row1 = 5'd0; bus_b.column = 13'd8191; bus_b.trg = 1'b1;
    @(posedge clk);
    #1 tb0 = cyc;
    bus_b.trg = 1'b0;
    seen = 1'b0;
    done_d = 0;
    while (!seen && cyc - tb0 < 4096 * K_B + LAT_B + 20) begin
      @(negedge clk);
      if (bus_b.done) begin
        seen = 1'b1;
        done_d = cyc - tb0;
      end
    end
    check("clamp_done_seen", 32'(seen), 1);
    check("clamp_done_edge", done_d, 4096 * K_B + LAT_B + 2);
    check("clamp_pulses", cnt_b, 4096);
    check("clamp_max_c", maxc_b, 4095);
    check("clamp_last_col", lastcol_b, 4095);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/matrix_dac_seq.md
MATRIX_DAC_SEQ -- requirements
Module: matrix_dac_seq

Interface
REQ-001 Parameter RD_LAT, default 2: read latency in cycles of the input RAM and coefficient RAM, counted from address to data (1..4).
REQ-002 Parameter K_DEPTH, default 32: fixed inner dimension; the k counter spans 0..31.
REQ-003 clk_250MHz  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 trg  in  1  start request, sampled in IDLE only.
REQ-006 row1  in  5  last output row index (rows = row1+1).
REQ-007 column  in  13  last output column index; values above 4095 are clamped to 4095.
REQ-008 in_addr  out  10  input RAM address, {r[4:0],k[4:0]}.
REQ-009 coe_addr  out  17  coefficient RAM address, {k[4:0],c[11:0]}.
REQ-010 mac_clr  out  1  clear the accumulator with the current product; aligned to RAM data.
REQ-011 mac_en  out  1  accumulate the current product; aligned to RAM data.
REQ-012 dac_out_en  out  1  one-cycle strobe: the accumulator result is valid.
REQ-013 out_row / out_col  out  5 / 12  indices of the result qualified by dac_out_en.
REQ-014 STATE  out  4  state encoding: IDLE=0, LOAD=1, RUN=2, DRAIN=3, DONE=4.
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 done  out  1  one-cycle completion pulse.

Function
REQ-017 In IDLE, trg=1 at a clock edge latches row1 and the clamped column into shadow registers and moves to LOAD; trg is ignored in every other state.
REQ-018 LOAD lasts one cycle, clears the r, c and k counters, then moves to RUN.
REQ-019 RUN issues one address pair per cycle; k increments innermost, then c, then r; RUN lasts N=(row1+1)*(column+1)*32 cycles.
REQ-020 After the final issue (r=row1, c=column, k=31), the state moves to DRAIN for RD_LAT+1 cycles, then to DONE for one cycle with done=1, then to IDLE.
REQ-021 The issue-time flags are delayed by exactly RD_LAT cycles to form mac_clr/mac_en: issue with k=0 gives mac_clr=1 and mac_en=0; issue with k>0 gives mac_en=1 and mac_clr=0.
REQ-022 dac_out_en pulses one cycle after the mac_en cycle for k=31, with out_row/out_col equal to that group's r/c; (row1+1)*(column+1) pulses are produced per run.
REQ-023 Address outputs hold their last value outside RUN; mac_clr, mac_en and dac_out_en are 0 outside their aligned cycles.
REQ-024 Counter wrap: on the k=31 issue, k goes to 0 and c increments; on c=column, c goes to 0 and r increments; no address exceeds the shadow limits.
REQ-025 done rises N+RD_LAT+2 edges after the edge that sampled trg; the last dac_out_en precedes done by at least 1 cycle.
REQ-026 trg asserted in the same cycle as done has no effect; a new run needs trg while in IDLE.

Reset
REQ-027 rst=1 forces, immediately and asynchronously, STATE=IDLE and all counters, shadow registers, addresses, delay pipes and outputs to 0.
REQ-028 rst asserted mid-run discards all in-flight strobes; no dac_out_en or done follows.

Configuration
REQ-029 With macro MATRIX_DAC_SEQ_ABORT_EN defined:
  - the module has an input port abort (1 bit);
  - abort=1 in LOAD, RUN or DRAIN returns the block to IDLE at the next edge and flushes the delay pipes;
  - done is not pulsed after an abort;
  - abort in IDLE or DONE is ignored.
REQ-030 Without the macro, the abort port does not exist and a run always completes.

Verification
REQ-031 RD_LAT=2, row1=0, column=0, trg pulse -> in_addr 0..31 and coe_addr k<<12 over 32 cycles; 1 dac_out_en pulse with out_row=0, out_col=0; done 36 edges after trg sampling.
REQ-032 row1=1, column=2 -> 192 RUN cycles; 6 dac_out_en pulses in order (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); mac_clr count = 6.
REQ-033 column=8191 -> coe_addr c field is capped at 4095; with row1=0, 4096 dac_out_en pulses.
REQ-034 trg re-pulsed during RUN, and again in the DONE cycle -> no restart and no change to the pulse count; busy stays 1 until after DONE.
REQ-035 rst pulsed at RUN cycle 10 -> STATE=0 and all outputs 0 in the same cycle; no later strobes.
REQ-036 With MATRIX_DAC_SEQ_ABORT_EN defined, abort in DRAIN -> IDLE at the next edge; the pending dac_out_en is suppressed and done stays 0.
